// File: rtl/imm_ext_arbiter_if.sv
// imm_ext_arbiter_if: request/result bundle for the shared
// immediate extender (two requesters in, one result out).
interface imm_ext_arbiter_if #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 16
);
  logic             req0;
  logic [IN_W-1:0]  imm0;
  logic             exop0;
  logic             req1;
  logic [IN_W-1:0]  imm1;
  logic             exop1;
  logic             gnt0;
  logic             gnt1;
  logic             out_valid;
  logic [OUT_W-1:0] out_data;
  logic             out_id;
  logic             out_ready;

  modport master (
    output req0, imm0, exop0,
    output req1, imm1, exop1,
    output out_ready,
    input  gnt0, gnt1,
    input  out_valid, out_data, out_id
  );

  modport slave (
    input  req0, imm0, exop0,
    input  req1, imm1, exop1,
    input  out_ready,
    output gnt0, gnt1,
    output out_valid, out_data, out_id
  );
endinterface

// File: rtl/imm_ext_arbiter.sv
// imm_ext_arbiter: round-robin share of one 12->16 immediate extender.
// Optional grant counters enabled by IMM_EXT_GRANT_CNT_EN.
module imm_ext_arbiter #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  imm_ext_arbiter_if.slave bus
`ifdef IMM_EXT_GRANT_CNT_EN
  ,
  output logic [15:0]      gnt_cnt0,
  output logic [15:0]      gnt_cnt1
`endif
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]       state;
  logic             gnt0_q;
  logic             gnt1_q;
  logic             id_q;
  logic             last_gnt;
  logic [OUT_W-1:0] data_q;

  logic             elig0;
  logic             elig1;
  logic             room;
  logic             cap;
  logic             drain;
  logic             win;
  logic [IN_W-1:0]  imm_w;
  logic             exop_w;
  logic [OUT_W-1:0] ext;

  // Eligibility, round-robin winner and extension of the winner.
  always_comb begin
    elig0  = bus.req0 & ~gnt0_q;
    elig1  = bus.req1 & ~gnt1_q;
    room   = (state == EMPTY) | bus.out_ready;
    cap    = room & (elig0 | elig1);
    drain  = (state == FULL) & bus.out_ready & ~cap;
    win    = elig1 & (~elig0 | ~last_gnt);
    imm_w  = win ? bus.imm1 : bus.imm0;
    exop_w = win ? bus.exop1 : bus.exop0;
    ext    = {{(OUT_W-IN_W){exop_w & imm_w[IN_W-1]}},
              imm_w};
  end

  // Result buffer, grant pulses and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= EMPTY;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      id_q     <= 1'b0;
      last_gnt <= 1'b1;
      data_q   <= '0;
    end else begin
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      unique case (1'b1)
        cap: begin
          state    <= FULL;
          gnt0_q   <= ~win;
          gnt1_q   <= win;
          id_q     <= win;
          last_gnt <= win;
          data_q   <= ext;
        end
        drain: begin
          state <= EMPTY;
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

`ifdef IMM_EXT_GRANT_CNT_EN
  // Per-requester grant counters, wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else if (cap) begin
      if (win) gnt_cnt1 <= gnt_cnt1 + 16'd1;
      else     gnt_cnt0 <= gnt_cnt0 + 16'd1;
    end
  end
`endif

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.out_valid = (state == FULL);
  assign bus.out_data  = data_q;
  assign bus.out_id    = id_q;

endmodule

// File: doc/imm_ext_arbiter.md
Name: imm_ext_arbiter

Overview:
- Shares one 12-to-16 immediate extender between two requesters: port 0 is the branch-target path and port 1 is the load/store offset path.
- Arbitrates round-robin, latches the winning immediate and extend mode, and produces a registered 16-bit result with a valid/ready output handshake.
- Sits between decode and the address/ALU datapath, so only one extender instance is needed in the core.

Parameters:
- IN_W, 12, immediate input width.
- OUT_W, 16, extended output width; must be greater than IN_W.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 request.
- imm0  input  IN_W  requester 0 immediate.
- exop0  input  1  requester 0 mode: 1 = sign-extend, 0 = zero-extend.
- req1  input  1  requester 1 request.
- imm1  input  IN_W  requester 1 immediate.
- exop1  input  1  requester 1 mode.
- gnt0  output  1  one-cycle grant pulse to requester 0.
- gnt1  output  1  one-cycle grant pulse to requester 1.
- out_valid  output  1  result register holds valid data.
- out_data  output  OUT_W  extended result.
- out_id  output  1  id of the requester owning out_data.
- out_ready  input  1  consumer accepts out_data.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_id=0, gnt0=gnt1=0, last_gnt=1 (so requester 0 wins the first tie).
- State: EMPTY (out_valid=0) or FULL (out_valid=1). The result register is a one-entry buffer.
- A capture may occur at an edge if:
  - the state is EMPTY, or
  - the state is FULL and out_ready=1 at that edge (transfer and capture in the same edge, giving back-to-back throughput of one result per cycle).
- Eligibility: reqX=1 and gntX=0 in the current cycle. A requester whose gnt is high this cycle is masked, which prevents double service of a request still held high.
- Arbitration:
  - One eligible requester: it wins.
  - Both eligible: the requester not equal to last_gnt wins.
  - last_gnt updates on every capture.
- On a capture at edge E, the following hold for the cycle E to E+1:
  - out_valid=1 and out_id=winner.
  - gnt[winner]=1 for exactly that cycle.
  - out_data: if exop=1, {(OUT_W-IN_W) copies of imm[IN_W-1], imm}; if exop=0, {(OUT_W-IN_W) zeros, imm}.
- Latency: request to valid result is 1 cycle.
- Requester protocol: hold reqX, immX and exopX stable until gntX is observed. The value sampled is the one present at the capture edge.
- Transfer without capture (FULL, out_ready=1, no eligible requester): state goes to EMPTY, out_valid=0, and out_data/out_id hold their last values.
- FULL with out_ready=0: out_data, out_id and out_valid hold. No capture occurs, and gnt0=gnt1=0 after the first cycle.
- Simultaneous requests: the two ports alternate strictly while both remain asserted.
- Reset mid-operation: any pending result is discarded without transfer, and all state returns to the reset values at that edge. Requesters must re-present their requests after reset.
- out_ready while EMPTY: ignored.

Optional Feature:
- Macro: IMM_EXT_GRANT_CNT_EN.
- When defined, adds the following output ports:
  - gnt_cnt0  output  16  count of grants to requester 0.
  - gnt_cnt1  output  16  count of grants to requester 1.
  - Each counter increments on every capture for that requester, wraps from 0xFFFF to 0x0000, and resets to 0.
- When undefined, these ports and counters are absent and the behaviour is otherwise identical.

Test Plan:
- Sign-extend: req0=1, imm0=12'h9F2, exop0=1, out_ready=1 → next cycle out_valid=1, out_data=16'hF9F2, out_id=0, gnt0 pulse of 1 cycle.
- Zero-extend and positive value:
  - req1 with imm1=12'h9F2, exop1=0 → out_data=16'h09F2, out_id=1.
  - imm1=12'h002, exop1=1 → out_data=16'h0002.
- Contention, out_ready=1:
  - Stimulus: req0 and req1 held high continuously; imm0=12'h800, exop0=1; imm1=12'h7FF, exop1=1.
  - Expected grants: 0, 1, 0, 1 on consecutive cycles.
  - Expected data: alternating 16'hF800 and 16'h07FF, out_valid high continuously.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles after a capture of imm0=12'h123.
  - Expected: out_data=16'h0123 held stable, no further gnt, and req1 pending.
  - When out_ready=1, the transfer and capture of req1 occur at the same edge.
- Reset mid-operation:
  - Stimulus: assert reset while out_valid=1 and out_ready=0.
  - Expected at the next edge: out_valid=0, gnt=0, and with both reqs high after reset, requester 0 is granted first.
- With IMM_EXT_GRANT_CNT_EN defined: after the 4-grant contention sequence, gnt_cnt0=2 and gnt_cnt1=2; a preloaded 0xFFFF wraps to 0x0000.
